// File: rtl/dense_argmax.sv
// dense_argmax
//   Captures OUT_COUNT signed scores written by the dense stage, scans them
//   for the maximum on a start pulse, and presents the winning class index
//   and score on a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   wrEn       score write strobe (accepted only while idle)
//   wrAdr      score index being written (indices >= OUT_COUNT are dropped)
//   wrData     signed score
//   start      one-cycle pulse that launches a scan (ignored unless idle)
//   busy       high while scanning or holding a result
//   outValid   result valid
//   outReady   consumer accepts the result
//   classIdx   index of the maximum score (lowest index wins ties)
//   classScore maximum score value
module dense_argmax #(
   parameter int OUT_COUNT = 10,
   parameter int DATA_SIZE = 32,
   localparam int IW = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wrEn,
   input  logic [IW-1:0]               wrAdr,
   input  logic signed [DATA_SIZE-1:0] wrData,
   input  logic                        start,
   output logic                        busy,
   output logic                        outValid,
   input  logic                        outReady,
   output logic [IW-1:0]               classIdx,
   output logic signed [DATA_SIZE-1:0] classScore
);

   localparam logic [IW:0]   COUNT = (IW + 1)'(OUT_COUNT);
   localparam logic [IW-1:0] LAST  = IW'(OUT_COUNT - 1);

   typedef enum logic [1:0] {IDLE, SCAN, OUT} stateT;

   stateT                       state;
   stateT                       nextState;
   logic signed [DATA_SIZE-1:0] scoreBuf [OUT_COUNT];
   logic [IW-1:0]               scanIdx;
   logic [IW-1:0]               bestIdx;
   logic signed [DATA_SIZE-1:0] bestVal;
   logic                        wrHit;

   always_comb begin
      wrHit = wrEn && ({1'b0, wrAdr} < COUNT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      busy      = 1'b0;
      outValid  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               nextState = (OUT_COUNT == 1) ? OUT : SCAN;
            end
         end
         SCAN: begin
            busy = 1'b1;
            if (scanIdx == LAST) begin
               nextState = OUT;
            end
         end
         OUT: begin
            busy     = 1'b1;
            outValid = 1'b1;
            if (outReady) begin
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < OUT_COUNT; i++) begin
            scoreBuf[i] <= '0;
         end
         scanIdx <= '0;
         bestIdx <= '0;
         bestVal <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (wrHit) begin
                  scoreBuf[wrAdr] <= wrData;
               end
               if (start) begin
                  bestIdx <= '0;
                  // A same-cycle write to entry 0 must seed the scan, since
                  // scoreBuf[0] only updates on this very edge.
                  bestVal <= (wrHit && (wrAdr == '0)) ? wrData : scoreBuf[0];
                  scanIdx <= IW'(1);
               end
            end
            SCAN: begin
               if (scoreBuf[scanIdx] > bestVal) begin
                  bestIdx <= scanIdx;
                  bestVal <= scoreBuf[scanIdx];
               end
               if (scanIdx != LAST) begin
                  scanIdx <= scanIdx + IW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      classIdx   = bestIdx;
      classScore = bestVal;
   end

endmodule

// File: tb/tb_dense_argmax.sv
module tb_dense_argmax;

   logic               clk = 1'b0;
   logic               rst;
   logic               wrEn;
   logic [3:0]         wrAdr;
   logic signed [31:0] wrData;
   logic               start;
   logic               busy;
   logic               outValid;
   logic               outReady;
   logic [3:0]         classIdx;
   logic signed [31:0] classScore;

   logic               wrEn1;
   logic [0:0]         wrAdr1;
   logic signed [15:0] wrData1;
   logic               start1;
   logic               busy1;
   logic               outValid1;
   logic               outReady1;
   logic [0:0]         classIdx1;
   logic signed [15:0] classScore1;

   int vectors = 0;
   int miscompares = 0;
   int model [10];

   always #5 clk = ~clk;

   dense_argmax dut (
      .clk(clk), .rst(rst), .wrEn(wrEn), .wrAdr(wrAdr), .wrData(wrData),
      .start(start), .busy(busy), .outValid(outValid), .outReady(outReady),
      .classIdx(classIdx), .classScore(classScore)
   );

   dense_argmax #(.OUT_COUNT(1), .DATA_SIZE(16)) dutOne (
      .clk(clk), .rst(rst), .wrEn(wrEn1), .wrAdr(wrAdr1), .wrData(wrData1),
      .start(start1), .busy(busy1), .outValid(outValid1), .outReady(outReady1),
      .classIdx(classIdx1), .classScore(classScore1)
   );

   // Reference: first index holding the largest signed value.
   function automatic void findMax(output int idx, output int val);
      idx = 0;
      val = model[0];
      for (int i = 1; i < 10; i++) begin
         if (model[i] > val) begin
            idx = i;
            val = model[i];
         end
      end
   endfunction

   // Write one score while idle; the model follows only in-range writes.
   task automatic writeScore(input int adr, input int data);
      wrEn = 1'b1;
      wrAdr = 4'(adr);
      wrData = data;
      @(negedge clk);
      wrEn = 1'b0;
      if (adr < 10) model[adr] = data;
   endtask

   task automatic loadAll(input int s [10]);
      for (int i = 0; i < 10; i++) writeScore(i, s[i]);
   endtask

   // One full scan + transfer. poke drives writes/starts during the hold.
   task automatic doScan(input string tag, input bit readyEarly, input int hold, input bit poke);
      int eIdx, eVal, lat;
      findMax(eIdx, eVal);
      outReady = readyEarly;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL %s busy_after_start got=%0b want=1", tag, busy);
      end
      lat = 0;
      while (outValid !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      vectors++;
      if (lat != 9) begin
         miscompares++;
         $display("FAIL %s latency got=%0d want=9", tag, lat);
      end
      vectors++;
      if (classIdx !== 4'(eIdx)) begin
         miscompares++;
         $display("FAIL %s classIdx got=%0d want=%0d", tag, classIdx, eIdx);
      end
      vectors++;
      if (classScore !== eVal) begin
         miscompares++;
         $display("FAIL %s classScore got=%0d want=%0d", tag, classScore, eVal);
      end
      if (!readyEarly) begin
         for (int c = 0; c < hold; c++) begin
            if (poke) begin
               wrEn = 1'b1;
               wrAdr = 4'($urandom_range(0, 9));
               wrData = 32'sd99999;
               start = 1'b1;
            end
            @(negedge clk);
            vectors++;
            if (outValid !== 1'b1 || classIdx !== 4'(eIdx) || classScore !== eVal) begin
               miscompares++;
               $display("FAIL %s hold_stable cyc=%0d got v=%0b i=%0d s=%0d want v=1 i=%0d s=%0d",
                        tag, c, outValid, classIdx, classScore, eIdx, eVal);
            end
         end
         wrEn = 1'b0;
         start = 1'b0;
         outReady = 1'b1;
         @(negedge clk);
      end else begin
         @(negedge clk);
      end
      outReady = 1'b0;
      vectors++;
      if (outValid !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL %s after_transfer got v=%0b busy=%0b want 0/0", tag, outValid, busy);
      end
   endtask

   task automatic test_reset;
      #3;
      vectors++;
      if (busy !== 1'b0 || outValid !== 1'b0 || classIdx !== 4'd0 || classScore !== 32'sd0) begin
         miscompares++;
         $display("FAIL reset_outputs got busy=%0b v=%0b i=%0d s=%0d want all 0",
                  busy, outValid, classIdx, classScore);
      end
      @(negedge clk);
      rst = 1'b1;
      // Buffer must read back as all zeros: a scan of a fresh buffer yields 0/0.
      doScan("reset_buffer", 1'b1, 0, 1'b0);
   endtask

   task automatic test_basic;
      loadAll('{5, -3, 12, 7, 12, 0, -100, 11, 2, 1});
      doScan("basic_tie", 1'b0, 0, 1'b0);
   endtask

   task automatic test_negative;
      loadAll('{-50, -20, -70, -20, -30, -40, -60, -80, -25, -90});
      doScan("negative", 1'b1, 0, 1'b0);
   endtask

   task automatic test_backpressure;
      doScan("backpressure", 1'b0, 20, 1'b1);
      doScan("after_poke", 1'b1, 0, 1'b0);
   endtask

   task automatic test_bypass;
      for (int i = 1; i < 10; i++) writeScore(i, int'($urandom_range(0, 200)) - 100);
      writeScore(15, 5000);
      wrEn = 1'b1;
      wrAdr = 4'd0;
      wrData = 32'sd1000;
      model[0] = 1000;
      doScan("bypass", 1'b0, 1, 1'b0);
      writeScore(15, 7000);
      doScan("adr_out_of_range", 1'b1, 0, 1'b0);
   endtask

   task automatic test_reset_mid;
      bit sawValid;
      loadAll('{77, 1, 2, 3, 4, 5, 6, 7, 8, 9});
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      vectors++;
      if (busy !== 1'b0 || outValid !== 1'b0 || classIdx !== 4'd0 || classScore !== 32'sd0) begin
         miscompares++;
         $display("FAIL reset_mid_outputs got busy=%0b v=%0b i=%0d s=%0d want all 0",
                  busy, outValid, classIdx, classScore);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 10; i++) model[i] = 0;
      sawValid = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (outValid === 1'b1) sawValid = 1'b1;
      end
      vectors++;
      if (sawValid) begin
         miscompares++;
         $display("FAIL reset_mid_no_result got outValid pulse want none");
      end
      for (int i = 0; i < 10; i++) writeScore(i, int'($urandom_range(0, 2000)) - 1000);
      doScan("reset_mid_reload", 1'b0, 2, 1'b0);
   endtask

   task automatic test_random;
      for (int it = 0; it < 12; it++) begin
         for (int i = 0; i < 10; i++) begin
            case (it % 3)
               0: model[i] = int'($urandom);
               1: model[i] = int'($urandom_range(0, 6)) - 3;
               default: model[i] = -int'($urandom_range(1, 1 << 30));
            endcase
         end
         loadAll(model);
         writeScore(int'($urandom_range(10, 15)), int'($urandom));
         doScan("random", 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0);
      end
   endtask

   task automatic test_back_to_back;
      loadAll('{3, 9, -4, 9, 0, 1, 2, 8, 9, -9});
      doScan("b2b_first", 1'b1, 0, 1'b0);
      doScan("b2b_second", 1'b0, 0, 1'b0);
   endtask

   task automatic test_single;
      wrEn1 = 1'b1;
      wrAdr1 = 1'b0;
      wrData1 = -16'sd7;
      @(negedge clk);
      wrEn1 = 1'b0;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      vectors++;
      if (outValid1 !== 1'b1 || busy1 !== 1'b1) begin
         miscompares++;
         $display("FAIL single_valid got v=%0b busy=%0b want 1/1", outValid1, busy1);
      end
      vectors++;
      if (classIdx1 !== 1'b0 || classScore1 !== -16'sd7) begin
         miscompares++;
         $display("FAIL single_result got i=%0d s=%0d want i=0 s=-7", classIdx1, classScore1);
      end
      outReady1 = 1'b1;
      @(negedge clk);
      outReady1 = 1'b0;
      vectors++;
      if (outValid1 !== 1'b0 || busy1 !== 1'b0) begin
         miscompares++;
         $display("FAIL single_transfer got v=%0b busy=%0b want 0/0", outValid1, busy1);
      end
   endtask

   initial begin
      rst = 1'b0;
      wrEn = 1'b0; wrAdr = '0; wrData = '0; start = 1'b0; outReady = 1'b0;
      wrEn1 = 1'b0; wrAdr1 = '0; wrData1 = '0; start1 = 1'b0; outReady1 = 1'b0;
      for (int i = 0; i < 10; i++) model[i] = 0;
      test_reset();
      test_basic();
      test_negative();
      test_backpressure();
      test_bypass();
      test_reset_mid();
      test_random();
      test_back_to_back();
      test_single();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/dense_argmax.md
# dense_argmax

Classification stage directly downstream of the dense layer datapath. It captures the OUT_COUNT signed scores the dense stage writes through its output-buffer address/data port. On a start pulse it scans them sequentially for the maximum. It then presents the winning class index and score on a valid/ready output handshake to the result interface.

## Interface

- OUT_COUNT, default 10: number of scores/classes; must be ≥ 1.
- DATA_SIZE, default 32: score width, two's-complement signed.
- IW, derived: clogb2(OUT_COUNT), the index width. It is a localparam, not overridable.

Ports:

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately).
- wrEn  in  1  score write strobe from the dense stage.
- wrAdr  in  IW  score index being written.
- wrData  in  DATA_SIZE  signed score.
- start  in  1  one-cycle pulse after the last score is written (driven from the dense stage's calcDone/putData).
- busy  out  1  high in SCAN and OUT.
- outValid  out  1  result valid.
- outReady  in  1  consumer accepts the result.
- classIdx  out  IW  index of the maximum score.
- classScore  out  DATA_SIZE  maximum score value.

## Operation

- Storage is OUT_COUNT registers of DATA_SIZE bits (scoreBuf).
  - They are cleared to 0 on reset and never cleared otherwise.
- Writes:
  - In IDLE, wrEn=1 with wrAdr<OUT_COUNT writes scoreBuf[wrAdr]=wrData.
  - wrAdr≥OUT_COUNT is ignored.
  - In SCAN/OUT all writes are ignored; the buffer is frozen.
- FSM states: IDLE, SCAN, OUT.
- IDLE, start=1:
  - Load bestIdx=0, bestVal=scoreBuf[0] and scanIdx=1.
  - If OUT_COUNT==1, go to OUT; else go to SCAN.
- Write and start in the same IDLE cycle:
  - The write commits and start is accepted.
  - If wrAdr==0, bestVal takes wrData (bypass).
  - Otherwise the write lands before SCAN reads that entry.
- SCAN, each cycle:
  - If scoreBuf[scanIdx] > bestVal (signed, strict), update bestIdx=scanIdx and bestVal=scoreBuf[scanIdx].
  - When scanIdx==OUT_COUNT-1, go to OUT; else increment scanIdx.
- Ties resolve to the lowest index, because the comparison is strict.
- OUT:
  - outValid=1; classIdx=bestIdx and classScore=bestVal are held stable.
  - When outValid and outReady are both high at a clock edge, go to IDLE.
- start outside IDLE is ignored; it is not queued.
- The comparison is a full DATA_SIZE signed compare with no truncation or saturation.
- Reset mid-operation (any state) aborts the operation. Next state is IDLE with buffer and outputs zeroed; no result is emitted.

## Timing

- Reset values: busy=0, outValid=0, classIdx=0, classScore=0, state IDLE, scoreBuf all 0.
- A write is visible in scoreBuf on the edge that samples wrEn.
- Edge E0 samples start. Scan edges E1…E(OUT_COUNT-1) each examine one entry.
- outValid rises after edge E(OUT_COUNT-1):
  - that is OUT_COUNT-1 edges after E0 (9 for OUT_COUNT=10);
  - for OUT_COUNT=1, outValid rises after E0.
- busy rises after E0 and falls on the same edge outValid falls.
- outValid may not depend combinationally on outReady.
- outReady may already be high when outValid rises. The transfer then completes on the first edge with outValid=1, and the block is back in IDLE one cycle later.
- A new start is accepted in the first IDLE cycle after the transfer edge.
- Throughput: at most one result per OUT_COUNT+1 cycles, excluding the write phase.

## Test plan

- Reset then load scores 0..9 = {5,-3,12,7,12,0,-100,11,2,1}; pulse start → outValid rises 9 edges later with classIdx=2 and classScore=12 (tie with index 4 resolves low); outReady=1 → outValid falls next edge and busy=0.
- All scores negative {-50,-20,-70,-20,…,-90}; start → classIdx=1, classScore=-20; this checks the signed compare against the unsigned interpretation (e.g. 0xFFFFFFEC).
- Backpressure: hold outReady=0 for 20 cycles after outValid → outValid, classIdx and classScore stay stable. Writes and start issued during the hold are ignored, and the result is unchanged after release.
- Same-cycle wrEn(wrAdr=0, wrData=1000) with start, other entries ≤100 → classIdx=0, classScore=1000. Also write wrAdr=15 → no buffer change.
- Assert rst=0 asynchronously in the middle of SCAN (scanIdx=4) → outputs zero immediately and no outValid pulse. Then reload and start → correct result after 9 edges.
- Parameter OUT_COUNT=1, DATA_SIZE=16: write -7 to index 0, start → outValid after one edge, classIdx=0, classScore=-7.
